// File: rtl/pong_pkg.sv
// Shared definitions for the pong video path: play-field defaults, colours,
// coordinate widths and the scanner state encoding.
`default_nettype none

package pong_pkg;

  localparam int WIDTH_DEF  = 240;
  localparam int HEIGHT_DEF = 320;
  localparam int X_W        = 8;
  localparam int Y_W        = 9;

  localparam logic [15:0] BALL_COLOUR_DEF   = 16'hFFFF;
  localparam logic [15:0] PADDLE_COLOUR_DEF = 16'h07E0;
  localparam logic [15:0] BG_COLOUR_DEF     = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESENT = 3'd1,
    S_LATCH   = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } scan_state_t;

  // Ball wins over paddle when both objects claim the same pixel.
  function automatic logic [15:0] pick_colour(
    input logic        ball,
    input logic        paddle,
    input logic [15:0] ball_c,
    input logic [15:0] paddle_c,
    input logic [15:0] bg_c
  );
    if (ball)
      return ball_c;
    else if (paddle)
      return paddle_c;
    else
      return bg_c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_counter.sv
// Raster x/y counter: x runs fastest and wraps at WIDTH-1, y stops at HEIGHT-1.
`default_nettype none

module scan_counter
  import pong_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clear,
  input  logic           i_advance,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_last
);

  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end = (r_x == X_MAX);
  assign w_y_end = (r_y == Y_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_advance) begin
      if (w_x_end) begin
        r_x <= '0;
        if (!w_y_end)
          r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end && w_y_end;

endmodule

`default_nettype wire

// File: rtl/pixel_scanner.sv
// Frame scanner: walks the play field in raster order, colours each pixel from
// the registered object flags and offers it to the LCD writer via valid/ready.
`default_nettype none

module pixel_scanner
  import pong_pkg::*;
#(
  parameter int          WIDTH         = WIDTH_DEF,
  parameter int          HEIGHT        = HEIGHT_DEF,
  parameter logic [15:0] BALL_COLOUR   = BALL_COLOUR_DEF,
  parameter logic [15:0] PADDLE_COLOUR = PADDLE_COLOUR_DEF,
  parameter logic [15:0] BG_COLOUR     = BG_COLOUR_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_draw_ball,
  input  logic           i_draw_paddle,
  input  logic           i_pixel_ready,
  output logic [X_W-1:0] o_x_count,
  output logic [Y_W-1:0] o_y_count,
  output logic [15:0]    o_pixel_data,
  output logic           o_pixel_write,
  output logic           o_busy,
  output logic           o_frame_done
);

  scan_state_t r_state;
  logic [15:0] r_pixel_data;
  logic        r_pixel_write;
  logic        r_busy;
  logic        r_frame_done;

  logic        w_last;
  logic        w_accept;
  logic        w_advance;
  logic        w_clear;

  assign w_accept  = (r_state == S_WRITE) && i_pixel_ready;
  assign w_advance = w_accept && !w_last;
  assign w_clear   = (r_state == S_DONE);

  scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_x       (o_x_count),
    .o_y       (o_y_count),
    .o_last    (w_last)
  );

  // Flags trail the coordinates by one cycle, so they are only sampled
  // leaving LATCH; data and coordinates then stay frozen through WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pixel_data  <= BG_COLOUR;
      r_pixel_write <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_PRESENT;
            r_busy  <= 1'b1;
          end
        end
        S_PRESENT: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_pixel_data  <= pick_colour(i_draw_ball, i_draw_paddle,
                                       BALL_COLOUR, PADDLE_COLOUR, BG_COLOUR);
          r_pixel_write <= 1'b1;
          r_state       <= S_WRITE;
        end
        S_WRITE: begin
          if (i_pixel_ready) begin
            r_pixel_write <= 1'b0;
            if (w_last) begin
              r_state      <= S_DONE;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= S_PRESENT;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state       <= S_IDLE;
          r_pixel_write <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_pixel_data  = r_pixel_data;
  assign o_pixel_write = r_pixel_write;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_pixel_scanner.sv
// Directed bench for pixel_scanner: scoreboarded 16x12 frames plus a 4x3 timing check.
`default_nettype none

module tb_pixel_scanner;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int BX = 8;
  localparam int BY = 6;
  localparam int PX = 10;
  localparam int PY = 5;

  typedef struct {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pix_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic        start       = 1'b0;
  logic        draw_ball   = 1'b0;
  logic        draw_paddle = 1'b0;
  logic        ready       = 1'b1;
  logic [7:0]  x;
  logic [8:0]  y;
  logic [15:0] data;
  logic        write;
  logic        busy;
  logic        done;

  logic        s_start = 1'b0;
  logic [7:0]  s_x;
  logic [8:0]  s_y;
  logic [15:0] s_data;
  logic        s_write;
  logic        s_busy;
  logic        s_done;

  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  int   nwrites  = 0;
  int   stall_n  = 0;
  bit   flags_on = 0;
  bit   stall_en = 0;
  pix_t q[$];
  pix_t mon_e;

  logic        prev_write = 1'b0;
  logic        prev_ready = 1'b1;
  logic [7:0]  prev_x;
  logic [8:0]  prev_y;
  logic [15:0] prev_d;

  int          s_writes = 0;
  int          s_ex = 0;
  int          s_ey = 0;
  int          s_last_x = -1;
  int          s_last_y = -1;

  always #5 clk = ~clk;

  pixel_scanner #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_draw_ball   (draw_ball),
    .i_draw_paddle (draw_paddle),
    .i_pixel_ready (ready),
    .o_x_count     (x),
    .o_y_count     (y),
    .o_pixel_data  (data),
    .o_pixel_write (write),
    .o_busy        (busy),
    .o_frame_done  (done)
  );

  pixel_scanner #(.WIDTH(4), .HEIGHT(3)) dut_s (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (s_start),
    .i_draw_ball   (1'b0),
    .i_draw_paddle (1'b0),
    .i_pixel_ready (1'b1),
    .o_x_count     (s_x),
    .o_y_count     (s_y),
    .o_pixel_data  (s_data),
    .o_pixel_write (s_write),
    .o_busy        (s_busy),
    .o_frame_done  (s_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upstream object controllers: registered hit flags, one cycle behind the coordinates.
  always @(posedge clk) begin
    draw_ball   <= flags_on && (x == BX) && (y == BY);
    draw_paddle <= flags_on && (((x == BX) && (y == BY)) || ((x == PX) && (y == PY)));
  end

  task automatic push_frame(input bit with_flags);
    pix_t p;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        p.x = 8'(xx);
        p.y = 9'(yy);
        if (with_flags && xx == BX && yy == BY)
          p.d = 16'hFFFF;
        else if (with_flags && xx == PX && yy == PY)
          p.d = 16'h07E0;
        else
          p.d = 16'h0000;
        q.push_back(p);
      end
    end
  endtask

  // Ready driver and scoreboard for the 16x12 instance share one process so
  // the sampled ready is the one the DUT sees at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_write = 1'b0;
      prev_ready = 1'b1;
      ready      = 1'b1;
    end else begin
      if (stall_en && write && x == 8'd3 && y == 9'd0 && stall_n < 5) begin
        ready = 1'b0;
        stall_n++;
      end else begin
        ready = 1'b1;
      end
      if (prev_write && !prev_ready) begin
        check("hold_write", 32'(write), 32'd1);
        check("hold_data",  32'(data),  32'(prev_d));
        check("hold_x",     32'(x),     32'(prev_x));
        check("hold_y",     32'(y),     32'(prev_y));
      end
      if (write && ready) begin
        if (q.size() == 0) begin
          check("extra_write", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("pix_x",    32'(x),    32'(mon_e.x));
          check("pix_y",    32'(y),    32'(mon_e.y));
          check("pix_data", 32'(data), 32'(mon_e.d));
          nwrites++;
        end
      end
      if (done)
        done_cnt++;
      prev_write = write;
      prev_ready = ready;
      prev_x     = x;
      prev_y     = y;
      prev_d     = data;
    end
  end

  always @(negedge clk) begin
    if (rst_n && s_write) begin
      check("s_x",    32'(s_x),    32'(s_ex));
      check("s_y",    32'(s_y),    32'(s_ey));
      check("s_data", 32'(s_data), 32'h0);
      s_last_x = int'(s_x);
      s_last_y = int'(s_y);
      s_writes++;
      if (s_ex == 3) begin
        s_ex = 0;
        s_ey++;
      end else begin
        s_ex++;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    bit hit;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    check("rst_x",     32'(x),     32'd0);
    check("rst_y",     32'(y),     32'd0);
    check("rst_data",  32'(data),  32'h0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 1: ball+paddle pixel, paddle-only pixel, stall at (3,0), stray starts.
    flags_on = 1;
    stall_en = 1;
    push_frame(1);
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("start_x", 32'(x), 32'd0);
    check("start_y", 32'(y), 32'd0);

    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = (x == 8'd5) && (y == 9'd2);
    end
    check("reach_5_2", 32'(hit), 32'd1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    wait_done("frame1_done_seen");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_x",    32'(x),    32'd0);
    check("idle_y",    32'(y),    32'd0);
    repeat (20) @(negedge clk);
    check("f1_done_cnt", 32'(done_cnt), 32'd1);
    check("f1_writes",   32'(nwrites),  32'(W * H));
    check("f1_q_empty",  32'(q.size()), 32'd0);
    check("f1_no_rerun", 32'(busy),     32'd0);
    check("f1_write_lo", 32'(write),    32'd0);
    check("stall_cycles", 32'(stall_n), 32'd5);

    // Frame 2: abandoned by an asynchronous reset in WRITE at (7,7).
    flags_on = 0;
    stall_en = 0;
    nwrites  = 0;
    push_frame(0);
    pulse_start();
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      hit = write && (x == 8'd7) && (y == 9'd7);
    end
    check("reach_7_7", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_write", 32'(write), 32'd0);
    check("arst_x",     32'(x),     32'd0);
    check("arst_y",     32'(y),     32'd0);
    check("arst_busy",  32'(busy),  32'd0);
    check("arst_done",  32'(done),  32'd0);
    q.delete();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_no_done", 32'(done_cnt), 32'd1);

    // Frame 3: full background frame must restart at (0,0).
    nwrites = 0;
    push_frame(0);
    pulse_start();
    wait_done("frame3_done_seen");
    repeat (5) @(negedge clk);
    check("f3_done_cnt", 32'(done_cnt), 32'd2);
    check("f3_writes",   32'(nwrites),  32'(W * H));
    check("f3_q_empty",  32'(q.size()), 32'd0);

    // 4x3 instance: frameDone in cycle 3*12+1 after the start edge.
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    cnt = 0;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      cnt++;
      #1 hit = s_done;
    end
    check("s_done_seen",  32'(hit),      32'd1);
    check("s_done_cycle", 32'(cnt + 1),  32'd37);
    repeat (3) @(negedge clk);
    check("s_writes",     32'(s_writes), 32'd12);
    check("s_last_x",     32'(s_last_x), 32'd3);
    check("s_last_y",     32'(s_last_y), 32'd2);
    check("s_busy_end",   32'(s_busy),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
